// File: rtl/branch_predictor_gen2.sv
// Branch predictor: PHT of saturating counters plus a tagged BTB, bimodal or gshare indexed.
// Lookup is combinational from the fetch PC; update is registered at branch/jump resolution.
module branch_predictor_gen2 #(
  parameter int unsigned PC_W    = 64,
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned MODE    = 0
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            en,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     mispred_cnt
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

  logic             btb_valid  [ENTRIES];
  logic             btb_jump   [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [PC_W-1:0]  btb_target [ENTRIES];
  logic [CNT_W-1:0] pht        [ENTRIES];
  logic [IDX_W-1:0] ghr;

  // Lookup path reads only registered state, so a same-cycle update is not visible
  logic [IDX_W-1:0] lk_bidx;
  logic [IDX_W-1:0] lk_pidx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_bidx     = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign lk_pidx     = (MODE == 1) ? (lk_bidx ^ ghr) : lk_bidx;
  assign pred_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
  assign pred_taken  = pred_hit && (btb_jump[lk_bidx] || pht[lk_pidx][CNT_W-1]);
  assign pred_target = pred_taken ? btb_target[lk_bidx] : lookup_pc + PC_W'(4);

  // Update decode; a jump takes priority over a branch flag raised alongside it
  logic [IDX_W-1:0] up_bidx;
  logic [IDX_W-1:0] up_pidx;
  logic [TAG_W-1:0] up_tag;
  logic             up_act;
  logic             up_br;
  logic             btb_wr;
  logic [CNT_W-1:0] pht_cur;
  logic [CNT_W-1:0] pht_nxt;
  logic             unused_upd_pc;

  assign up_bidx       = upd_pc[IDX_W+1:2];
  assign up_tag        = upd_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign up_pidx       = (MODE == 1) ? (up_bidx ^ ghr) : up_bidx;
  assign up_act        = en && upd_valid && (upd_is_branch || upd_is_jump);
  assign up_br         = up_act && upd_is_branch && !upd_is_jump;
  assign btb_wr        = up_act && (upd_is_jump || upd_taken);
  assign pht_cur       = pht[up_pidx];
  assign unused_upd_pc = ^upd_pc;

  always_comb begin
    pht_nxt = pht_cur;
    if (upd_taken) begin
      if (pht_cur != CNT_MAX) pht_nxt = pht_cur + CNT_W'(1);
    end else begin
      if (pht_cur != '0) pht_nxt = pht_cur - CNT_W'(1);
    end
  end

  // BTB storage
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[IDX_W'(i)]  <= 1'b0;
        btb_jump[IDX_W'(i)]   <= 1'b0;
        btb_tag[IDX_W'(i)]    <= '0;
        btb_target[IDX_W'(i)] <= '0;
      end
    end else if (btb_wr) begin
      btb_valid[up_bidx]  <= 1'b1;
      btb_jump[up_bidx]   <= upd_is_jump;
      btb_tag[up_bidx]    <= up_tag;
      btb_target[up_bidx] <= upd_target;
    end
  end

  // Direction state: PHT and non-speculative global history
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[IDX_W'(i)] <= CNT_INIT;
      ghr <= '0;
    end else if (up_br) begin
      pht[up_pidx] <= pht_nxt;
      ghr          <= {ghr[IDX_W-2:0], upd_taken};
    end
  end

  // Saturating mispredict statistics
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mispred_cnt <= '0;
    end else if (up_act && upd_mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gen2.sv
// Scoreboard bench for branch_predictor_gen2: bimodal and gshare instances, directed vectors.
module tb_branch_predictor_gen2;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en;
  logic [63:0] lookup_pc;
  logic        upd_valid0, upd_valid1;
  logic [63:0] upd_pc;
  logic        upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
  logic [63:0] upd_target;
  logic        hit0, taken0, hit1, taken1;
  logic [63:0] tgt0, tgt1;
  logic [31:0] cnt0, cnt1;

  always #5 clk = ~clk;

  branch_predictor_gen2 #(.PC_W(64), .ENTRIES(32), .CNT_W(2), .TAG_W(8), .MODE(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .en(en), .lookup_pc(lookup_pc),
    .pred_hit(hit0), .pred_taken(taken0), .pred_target(tgt0),
    .upd_valid(upd_valid0), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispred_cnt(cnt0)
  );

  branch_predictor_gen2 #(.PC_W(64), .ENTRIES(32), .CNT_W(2), .TAG_W(8), .MODE(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .en(en), .lookup_pc(lookup_pc),
    .pred_hit(hit1), .pred_taken(taken1), .pred_target(tgt1),
    .upd_valid(upd_valid1), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispred_cnt(cnt1)
  );

  typedef struct {
    int          dut;
    bit          is_cnt;
    logic        hit;
    logic        taken;
    logic [63:0] tgt;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Monitor: pops one expectation per sample strobe and compares against the selected instance
  always @(negedge clk) begin
    if (chk_req) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: sample strobe with no expectation queued");
      end else begin
        exp_t e;
        logic        a_hit, a_taken;
        logic [63:0] a_tgt;
        logic [31:0] a_cnt;
        e       = exp_q.pop_front();
        a_hit   = (e.dut == 0) ? hit0   : hit1;
        a_taken = (e.dut == 0) ? taken0 : taken1;
        a_tgt   = (e.dut == 0) ? tgt0   : tgt1;
        a_cnt   = (e.dut == 0) ? cnt0   : cnt1;
        if (e.is_cnt) begin
          if (a_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL %s: mispred_cnt got %0d expected %0d", e.name, a_cnt, e.cnt);
          end
        end else if (a_hit !== e.hit || a_taken !== e.taken || a_tgt !== e.tgt) begin
          n_fail++;
          $display("FAIL %s: got hit=%b taken=%b target=%h expected hit=%b taken=%b target=%h",
                   e.name, a_hit, a_taken, a_tgt, e.hit, e.taken, e.tgt);
        end
      end
    end
  end

  // Every task starts and ends just after a rising edge
  task automatic push_lookup(input int d, input logic [63:0] pc, input logic h, input logic t,
                             input logic [63:0] tg, input string nm);
    exp_t e;
    e.dut = d; e.is_cnt = 1'b0; e.hit = h; e.taken = t; e.tgt = tg; e.cnt = '0; e.name = nm;
    lookup_pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int d, input logic [63:0] pc, input logic h, input logic t,
                       input logic [63:0] tg, input string nm);
    push_lookup(d, pc, h, t, tg, nm);
    sample();
  endtask

  task automatic check_cnt(input logic [31:0] c, input string nm);
    exp_t e;
    e.dut = 0; e.is_cnt = 1'b1; e.hit = 1'b0; e.taken = 1'b0; e.tgt = '0; e.cnt = c; e.name = nm;
    exp_q.push_back(e);
    sample();
  endtask

  task automatic drive_upd(input int d, input logic [63:0] pc, input logic br, input logic jp,
                           input logic tk, input logic [63:0] tg, input logic mp);
    upd_pc = pc; upd_is_branch = br; upd_is_jump = jp; upd_taken = tk;
    upd_target = tg; upd_mispredict = mp;
    upd_valid0 = (d == 0); upd_valid1 = (d == 1);
  endtask

  task automatic upd(input int d, input logic [63:0] pc, input logic br, input logic jp,
                     input logic tk, input logic [63:0] tg, input logic mp);
    drive_upd(d, pc, br, jp, tk, tg, mp);
    @(posedge clk);
    #1 upd_valid0 = 1'b0; upd_valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; en = 1'b1; lookup_pc = '0;
    upd_valid0 = 1'b0; upd_valid1 = 1'b0; upd_pc = '0; upd_is_branch = 1'b0;
    upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and PC+4 wrap
    check(0, 64'h100, 0, 0, 64'h104, "reset_lookup");
    check_cnt(32'd0, "reset_cnt");
    check(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, "target_wrap");

    // Same-cycle update and lookup of 0x40 sees the pre-update (empty) entry
    drive_upd(0, 64'h40, 1, 0, 1, 64'h20, 0);
    push_lookup(0, 64'h40, 0, 0, 64'h44, "no_bypass");
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
    @(posedge clk);
    #1 upd_valid0 = 1'b0;
    check(0, 64'h40, 1, 1, 64'h20, "alloc_taken");
    upd(0, 64'h40, 1, 0, 0, 64'h20, 0);
    upd(0, 64'h40, 1, 0, 0, 64'h20, 0);
    check(0, 64'h40, 1, 0, 64'h44, "pht_zero");

    // Saturation at 3: five taken, then two not-taken
    for (int i = 0; i < 5; i++) upd(0, 64'h40, 1, 0, 1, 64'h20, 0);
    check(0, 64'h40, 1, 1, 64'h20, "pht_sat");
    upd(0, 64'h40, 1, 0, 0, 64'h20, 0);
    check(0, 64'h40, 1, 1, 64'h20, "pht_3_to_2");
    upd(0, 64'h40, 1, 0, 0, 64'h20, 0);
    check(0, 64'h40, 1, 0, 64'h44, "pht_2_to_1");

    // Alias 0xC0 shares index 16 with a different tag
    check(0, 64'hC0, 0, 0, 64'hC4, "alias_miss");
    upd(0, 64'hC0, 1, 0, 1, 64'h500, 0);
    check(0, 64'hC0, 1, 1, 64'h500, "alias_alloc");
    check(0, 64'h40, 0, 0, 64'h44, "alias_evicted");

    // Jump predicted taken with PHT at 0
    upd(0, 64'h200, 1, 0, 0, 64'h0, 0);
    check(0, 64'h200, 0, 0, 64'h204, "nt_no_alloc");
    upd(0, 64'h200, 1, 1, 0, 64'h300, 0);
    check(0, 64'h200, 1, 1, 64'h300, "jump_taken");

    // en=0 freezes everything
    en = 1'b0;
    upd(0, 64'h280, 0, 1, 1, 64'h600, 1);
    en = 1'b1;
    check(0, 64'h280, 0, 0, 64'h284, "en0_no_btb");
    check(0, 64'h200, 1, 1, 64'h300, "en0_keep");
    check_cnt(32'd0, "en0_no_cnt");
    for (int i = 0; i < 3; i++) upd(0, 64'h200, 0, 1, 1, 64'h300, 1);
    check_cnt(32'd3, "mispred_3");

    // Update with neither flag set has no effect
    upd(0, 64'h340, 0, 0, 1, 64'h999, 0);
    check(0, 64'h340, 0, 0, 64'h344, "noop_upd");

    // Mid-run asynchronous reset
    #2 arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check(0, 64'h100, 0, 0, 64'h104, "midrst_lookup");
    check(0, 64'h200, 0, 0, 64'h204, "midrst_btb");
    check_cnt(32'd0, "midrst_cnt");

    // Gshare: history shifts change which PHT entry 0x40 reads
    check(1, 64'h40, 0, 0, 64'h44, "g_reset");
    upd(1, 64'h40, 1, 0, 1, 64'h20, 0);
    check(1, 64'h40, 1, 0, 64'h44, "g_ghr1_pidx17");
    upd(1, 64'h40, 1, 0, 1, 64'h20, 0);
    check(1, 64'h40, 1, 0, 64'h44, "g_ghr3_pidx19");
    upd(1, 64'h40, 1, 0, 1, 64'h20, 0);
    upd(1, 64'h4, 1, 0, 0, 64'h0, 0);
    upd(1, 64'h4, 1, 0, 0, 64'h0, 0);
    upd(1, 64'h4, 1, 0, 0, 64'h0, 0);
    upd(1, 64'hC, 1, 0, 1, 64'h80, 0);
    upd(1, 64'hC, 1, 0, 1, 64'h80, 0);
    check(1, 64'h40, 1, 1, 64'h20, "g_pht19_up");
    check(1, 64'hC, 1, 0, 64'h10, "g_pidx0");

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
